// File: rtl/kb_digit_entry_if.sv
// -----------------------------------------------------------------------------
// kb_digit_entry_if
//   Bundles the keyboard-decoder event stream and the digit-entry results so
//   that the entry block and whatever drives or observes it share a single
//   connection.
//
//   Decoder side (driven by master):
//     last_change  [8:0]         {extend, scan code} of the latest key event
//     key_valid                  one-cycle event strobe
//     key_down     [511:0]       key state vector, same edge as key_valid
//   Entry side (driven by slave):
//     entry_bcd    [4*DIGITS-1:0] live buffer, digit 0 (LSD) in [3:0]
//     entry_count  [CW-1:0]      digits held in the buffer, 0..DIGITS
//     commit_bcd   [4*DIGITS-1:0] last committed value
//     commit_pulse               one-cycle strobe when commit_bcd updates
//     overflow                   sticky, a digit was refused because full
//     busy                       high while an entry is in progress
// -----------------------------------------------------------------------------
interface kb_digit_entry_if #(
    parameter int DIGITS = 4,
    parameter int CW     = 3
);
    logic [8:0]            last_change;
    logic                  key_valid;
    logic [511:0]          key_down;

    logic [4*DIGITS-1:0]   entry_bcd;
    logic [CW-1:0]         entry_count;
    logic [4*DIGITS-1:0]   commit_bcd;
    logic                  commit_pulse;
    logic                  overflow;
    logic                  busy;

    modport master (
        output last_change,
        output key_valid,
        output key_down,
        input  entry_bcd,
        input  entry_count,
        input  commit_bcd,
        input  commit_pulse,
        input  overflow,
        input  busy
    );

    modport slave (
        input  last_change,
        input  key_valid,
        input  key_down,
        output entry_bcd,
        output entry_count,
        output commit_bcd,
        output commit_pulse,
        output overflow,
        output busy
    );
endinterface

// File: rtl/kb_digit_entry.sv
// -----------------------------------------------------------------------------
// kb_digit_entry
//   Builds a multi-digit decimal number from keyboard presses. Digits shift
//   into a BCD buffer from the right, Backspace drops the newest digit, Esc
//   clears, Enter commits the buffer to commit_bcd with a one-cycle pulse.
//   All outputs are registered: a key event shows up one edge later.
//
//   Ports:
//     i_clk    system clock
//     i_rst    synchronous, active-high reset (wins over a coincident event)
//     io_bus   kb_digit_entry_if.slave: decoder events in, entry results out
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | buffer empty, waiting for the first digit
//   ENTRY  | collecting digits, Backspace/Enter/Esc active
//   DONE   | value committed, buffer held for display until next digit/Esc
// -----------------------------------------------------------------------------
module kb_digit_entry #(
    parameter int DIGITS = 4,
    parameter int CW     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    kb_digit_entry_if.slave  io_bus
);

    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_NONE  = 3'd0,
        K_DIGIT = 3'd1,
        K_BKSP  = 3'd2,
        K_ENTER = 3'd3,
        K_ESC   = 3'd4
    } key_class_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_commit;
    logic             r_pulse;
    logic             r_ovf;
    logic             r_busy;

    logic [BW-1:0]    w_bcd_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [BW-1:0]    w_commit_nxt;
    logic             w_pulse_nxt;
    logic             w_ovf_nxt;

    logic             w_press;
    key_class_t       w_class;
    logic [3:0]       w_digit;
    logic             w_full;

    // Only presses count; a release arrives with the same strobe but its
    // key_down bit already cleared. Typematic repeats keep the bit set.
    assign w_press = io_bus.key_valid & io_bus.key_down[io_bus.last_change];
    assign w_full  = (r_cnt >= CW'(DIGITS));

    always_comb begin
        w_class = K_NONE;
        w_digit = 4'd0;
        if (w_press) begin
            case (io_bus.last_change)
                9'h045, 9'h070: begin w_class = K_DIGIT; w_digit = 4'd0; end
                9'h016, 9'h069: begin w_class = K_DIGIT; w_digit = 4'd1; end
                9'h01E, 9'h072: begin w_class = K_DIGIT; w_digit = 4'd2; end
                9'h026, 9'h07A: begin w_class = K_DIGIT; w_digit = 4'd3; end
                9'h025, 9'h06B: begin w_class = K_DIGIT; w_digit = 4'd4; end
                9'h02E, 9'h073: begin w_class = K_DIGIT; w_digit = 4'd5; end
                9'h036, 9'h074: begin w_class = K_DIGIT; w_digit = 4'd6; end
                9'h03D, 9'h06C: begin w_class = K_DIGIT; w_digit = 4'd7; end
                9'h03E, 9'h075: begin w_class = K_DIGIT; w_digit = 4'd8; end
                9'h046, 9'h07D: begin w_class = K_DIGIT; w_digit = 4'd9; end
                9'h066:         w_class = K_BKSP;
                9'h05A, 9'h15A: w_class = K_ENTER;
                9'h076:         w_class = K_ESC;
                default:        w_class = K_NONE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_class == K_DIGIT) begin
                    w_state_nxt = S_ENTRY;
                end
            end
            S_ENTRY: begin
                case (w_class)
                    // ENTRY always holds at least one digit, so a count of
                    // one means this Backspace empties the buffer.
                    K_BKSP:  if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
                    K_ENTER: w_state_nxt = S_DONE;
                    K_ESC:   w_state_nxt = S_IDLE;
                    default: w_state_nxt = S_ENTRY;
                endcase
            end
            S_DONE: begin
                case (w_class)
                    K_DIGIT: w_state_nxt = S_ENTRY;
                    K_ESC:   w_state_nxt = S_IDLE;
                    default: w_state_nxt = S_DONE;
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        w_bcd_nxt    = r_bcd;
        w_cnt_nxt    = r_cnt;
        w_commit_nxt = r_commit;
        w_pulse_nxt  = 1'b0;
        w_ovf_nxt    = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (w_class == K_DIGIT) begin
                    w_bcd_nxt = BW'(w_digit);
                    w_cnt_nxt = CW'(1);
                end
            end
            S_ENTRY: begin
                case (w_class)
                    K_DIGIT: begin
                        if (!w_full) begin
                            w_bcd_nxt = {r_bcd[BW-5:0], w_digit};
                            w_cnt_nxt = r_cnt + CW'(1);
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                    end
                    K_BKSP: begin
                        w_bcd_nxt = {4'd0, r_bcd[BW-1:4]};
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                    K_ENTER: begin
                        w_commit_nxt = r_bcd;
                        w_pulse_nxt  = 1'b1;
                    end
                    K_ESC: begin
                        w_bcd_nxt = '0;
                        w_cnt_nxt = '0;
                        w_ovf_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_DONE: begin
                case (w_class)
                    K_DIGIT: begin
                        w_bcd_nxt = BW'(w_digit);
                        w_cnt_nxt = CW'(1);
                        w_ovf_nxt = 1'b0;
                    end
                    K_ESC: begin
                        w_bcd_nxt = '0;
                        w_cnt_nxt = '0;
                        w_ovf_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_commit <= '0;
            r_pulse  <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_bcd    <= w_bcd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_commit <= w_commit_nxt;
            r_pulse  <= w_pulse_nxt;
            r_ovf    <= w_ovf_nxt;
            r_busy   <= (w_state_nxt == S_ENTRY);
        end
    end

    assign io_bus.entry_bcd    = r_bcd;
    assign io_bus.entry_count  = r_cnt;
    assign io_bus.commit_bcd   = r_commit;
    assign io_bus.commit_pulse = r_pulse;
    assign io_bus.overflow     = r_ovf;
    assign io_bus.busy         = r_busy;

endmodule

// File: tb/tb_kb_digit_entry.sv
// -----------------------------------------------------------------------------
// tb_kb_digit_entry
//   Directed key sequences against kb_digit_entry. A reference model holds the
//   entered digits as a queue of integers and rebuilds the BCD value by
//   arithmetic; every cycle the DUT outputs are compared against it, and
//   hand-computed literals pin key points of each sequence.
// -----------------------------------------------------------------------------
module tb_kb_digit_entry;

    localparam int DIGITS = 4;
    localparam int CW     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    kb_digit_entry_if #(.DIGITS(DIGITS), .CW(CW)) bus ();

    kb_digit_entry #(.DIGITS(DIGITS), .CW(CW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;
    int pulse_cnt = 0;

    int main_codes [10] = '{'h045, 'h016, 'h01E, 'h026, 'h025,
                            'h02E, 'h036, 'h03D, 'h03E, 'h046};
    int pad_codes  [10] = '{'h070, 'h069, 'h072, 'h07A, 'h06B,
                            'h073, 'h074, 'h06C, 'h075, 'h07D};

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 entry, 2 done.  class: 0 none, 1 digit, 2 bksp, 3 enter, 4 esc
    int          m_q[$];
    int          m_mode   = 0;
    logic [31:0] m_commit = '0;
    bit          m_pulse  = 1'b0;
    bit          m_ovf    = 1'b0;

    function automatic void classify(input int code, output int cls, output int d);
        cls = 0;
        d   = 0;
        for (int i = 0; i < 10; i++) begin
            if (code == main_codes[i] || code == pad_codes[i]) begin
                cls = 1;
                d   = i;
            end
        end
        if (code == 'h066) cls = 2;
        if (code == 'h05A || code == 'h15A) cls = 3;
        if (code == 'h076) cls = 4;
    endfunction

    function automatic logic [31:0] model_bcd();
        logic [31:0] acc;
        acc = '0;
        foreach (m_q[i]) acc = acc * 16 + 32'(m_q[i]);
        return acc;
    endfunction

    always @(posedge clk) begin
        int cls, d;
        if (rst) begin
            m_q.delete();
            m_mode   = 0;
            m_commit = '0;
            m_pulse  = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (bus.key_valid === 1'b1 && bus.key_down[bus.last_change] === 1'b1) begin
                classify(int'(bus.last_change), cls, d);
                case (m_mode)
                    0: if (cls == 1) begin
                        m_q.delete(); m_q.push_back(d); m_mode = 1;
                    end
                    1: case (cls)
                        1: if (m_q.size() < DIGITS) m_q.push_back(d); else m_ovf = 1'b1;
                        2: begin
                            void'(m_q.pop_back());
                            if (m_q.size() == 0) m_mode = 0;
                        end
                        3: begin m_commit = model_bcd(); m_pulse = 1'b1; m_mode = 2; end
                        4: begin m_q.delete(); m_ovf = 1'b0; m_mode = 0; end
                        default: ;
                    endcase
                    2: case (cls)
                        1: begin m_q.delete(); m_q.push_back(d); m_ovf = 1'b0; m_mode = 1; end
                        4: begin m_q.delete(); m_ovf = 1'b0; m_mode = 0; end
                        default: ;
                    endcase
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.commit_pulse === 1'b1) pulse_cnt++;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc.entry_bcd",    32'(bus.entry_bcd),    model_bcd());
            chk("cyc.entry_count",  32'(bus.entry_count),  32'(m_q.size()));
            chk("cyc.commit_bcd",   32'(bus.commit_bcd),   m_commit);
            chk("cyc.commit_pulse", 32'(bus.commit_pulse), 32'(m_pulse));
            chk("cyc.overflow",     32'(bus.overflow),     32'(m_ovf));
            chk("cyc.busy",         32'(bus.busy),         32'(m_mode == 1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [8:0] code);
        @(negedge clk);
        bus.key_down[code] = 1'b1;
        bus.last_change    = code;
        bus.key_valid      = 1'b1;
        @(negedge clk);
        bus.key_valid      = 1'b0;
        #1;
    endtask

    task automatic release_key(input logic [8:0] code);
        @(negedge clk);
        bus.key_down[code] = 1'b0;
        bus.last_change    = code;
        bus.key_valid      = 1'b1;
        @(negedge clk);
        bus.key_valid      = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] bcd, input logic [31:0] cnt,
                           input logic [31:0] ovf, input logic [31:0] busy);
        chk({tag, ".entry_bcd"},   32'(bus.entry_bcd),   bcd);
        chk({tag, ".entry_count"}, 32'(bus.entry_count), cnt);
        chk({tag, ".overflow"},    32'(bus.overflow),    ovf);
        chk({tag, ".busy"},        32'(bus.busy),        busy);
    endtask

    initial begin
        int p0;
        bus.last_change = '0;
        bus.key_valid   = 1'b0;
        bus.key_down    = '0;

        do_reset();
        check_en = 1'b1;
        chk_out("reset", 32'h0, 0, 0, 0);
        chk("reset.commit_bcd", 32'(bus.commit_bcd), 32'h0);
        chk("reset.commit_pulse", 32'(bus.commit_pulse), 32'h0);

        // 1: 1,2,3,Enter
        p0 = pulse_cnt;
        press(9'h016); press(9'h01E); press(9'h026);
        chk_out("t1.pre", 32'h0123, 3, 0, 1);
        press(9'h05A);
        chk_out("t1.done", 32'h0123, 3, 0, 0);
        chk("t1.commit_bcd", 32'(bus.commit_bcd), 32'h0123);
        chk("t1.pulse_hi", 32'(bus.commit_pulse), 32'h1);
        @(negedge clk); #1;
        chk("t1.pulse_lo", 32'(bus.commit_pulse), 32'h0);
        chk("t1.pulses", 32'(pulse_cnt - p0), 32'd1);

        // 2: keypad 9 with releases interleaved
        press(9'h076);
        release_key(9'h016);
        press(9'h07D);
        release_key(9'h07D);
        release_key(9'h01E);
        chk_out("t2", 32'h0009, 1, 0, 1);

        // 3: overflow on 5th digit, sticky through Backspace, cleared by Esc
        press(9'h076);
        press(9'h016); press(9'h01E); press(9'h026); press(9'h025); press(9'h02E);
        chk_out("t3.full", 32'h1234, 4, 1, 1);
        press(9'h066);
        chk_out("t3.bksp", 32'h0123, 3, 1, 1);
        press(9'h076);
        chk_out("t3.esc", 32'h0, 0, 0, 0);

        // 4: 4,7,Bksp,Bksp, then Enter from IDLE
        p0 = pulse_cnt;
        press(9'h025); press(9'h03D);
        chk_out("t4.47", 32'h0047, 2, 0, 1);
        press(9'h066);
        chk_out("t4.b1", 32'h0004, 1, 0, 1);
        press(9'h066);
        chk_out("t4.b2", 32'h0000, 0, 0, 0);
        press(9'h05A);
        repeat (2) @(negedge clk); #1;
        chk("t4.pulses", 32'(pulse_cnt - p0), 32'd0);
        chk("t4.commit_bcd", 32'(bus.commit_bcd), 32'h0123);

        // 5: commit 42 via extended Enter, Enter twice more in DONE, then 8
        p0 = pulse_cnt;
        press(9'h025); press(9'h01E); press(9'h15A);
        press(9'h05A); press(9'h05A);
        repeat (2) @(negedge clk); #1;
        chk("t5.pulses", 32'(pulse_cnt - p0), 32'd1);
        chk("t5.commit_bcd", 32'(bus.commit_bcd), 32'h0042);
        press(9'h066);
        chk_out("t5.bksp_done", 32'h0042, 2, 0, 0);
        press(9'h03E);
        chk_out("t5.new", 32'h0008, 1, 0, 1);
        chk("t5.commit_held", 32'(bus.commit_bcd), 32'h0042);

        // leading zeros, unknown code, typematic repeat
        press(9'h076);
        press(9'h045); press(9'h03D);
        chk_out("lz", 32'h0007, 2, 0, 1);
        press(9'h01C);
        chk_out("unknown", 32'h0007, 2, 0, 1);
        press(9'h03D);
        chk_out("repeat", 32'h0077, 3, 0, 1);

        // 6: rst together with Enter mid-entry
        p0 = pulse_cnt;
        @(negedge clk);
        rst = 1'b1;
        bus.key_down[9'h05A] = 1'b1;
        bus.last_change      = 9'h05A;
        bus.key_valid        = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        chk_out("t6", 32'h0, 0, 0, 0);
        chk("t6.commit_bcd", 32'(bus.commit_bcd), 32'h0);
        repeat (2) @(negedge clk); #1;
        chk("t6.pulses", 32'(pulse_cnt - p0), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
